// File: rtl/jtopl_pkg.sv
// Shared types and ROM tables for the OPL2 operator output stage.
// The tables are built at elaboration from the log-sine / exponent definitions.
package jtopl_pkg;

  typedef enum logic [1:0] {
    WAV_SINE  = 2'd0,
    WAV_HALF  = 2'd1,
    WAV_ABS   = 2'd2,
    WAV_QUART = 2'd3
  } wav_e;

  localparam logic [12:0] SUM_MAX = 13'h1FFF;

  typedef logic [255:0][11:0] logsin_tbl_t;
  typedef logic [255:0][9:0]  exp_tbl_t;

  typedef struct packed {
    logic [7:0] idx;
    logic       sign;
    logic       mute;
    logic [9:0] eg;
  } s1_t;

  typedef struct packed {
    logic [12:0] sum;
    logic        sign;
    logic        mute;
  } s2_t;

  // -log2(sin) of a quarter wave, 4.8 fixed point
  function automatic logsin_tbl_t logsin_init();
    logsin_tbl_t t;
    real x;
    for (int i = 0; i < 256; i++) begin
      x = -$ln($sin((real'(i) + 0.5) * 3.14159265358979 / 512.0)) / $ln(2.0) * 256.0;
      t[i] = 12'(int'(x));
    end
    return t;
  endfunction

  // fractional part of 2^(i/256), 0.10 fixed point
  function automatic exp_tbl_t exp_init();
    exp_tbl_t t;
    real x;
    for (int i = 0; i < 256; i++) begin
      x = ($pow(2.0, real'(i) / 256.0) - 1.0) * 1024.0;
      t[i] = 10'(int'(x));
    end
    return t;
  endfunction

endpackage

// File: rtl/jtopl_op_rom.sv
// Log-sine and exponent lookups, combinational read.
module jtopl_op_rom
  import jtopl_pkg::*;
(
  input  logic [7:0]  ls_addr_i,
  output logic [11:0] ls_data_o,
  input  logic [7:0]  exp_addr_i,
  output logic [9:0]  exp_data_o
);

  localparam logsin_tbl_t LOGSIN = logsin_init();
  localparam exp_tbl_t    EXPT   = exp_init();

  assign ls_data_o  = LOGSIN[ls_addr_i];
  assign exp_data_o = EXPT[exp_addr_i];

endmodule

// File: rtl/jtopl_op_wave.sv
// Operator output stage: phase modulation, waveform select, log-sine and
// exponent conversion to a signed linear sample. Three cen-gated stages.
module jtopl_op_wave
  import jtopl_pkg::*;
#(
  parameter int OUTW = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic [9:0]             phase_op,
  input  logic [9:0]             mod,
  input  logic [1:0]             wavsel,
  input  logic [9:0]             eg_atten,
  input  logic                   op_valid,
  output logic signed [OUTW-1:0] op_out,
  output logic                   op_out_valid
);

  s1_t        s1_d, s1_q;
  s2_t        s2_d, s2_q;
  logic [1:0] vld_q;
  logic [9:0] p;
  wav_e       wav;

  logic [11:0] ls;
  logic [9:0]  ex;
  logic [13:0] sum_full;
  logic [11:0] m;
  logic signed [OUTW-1:0] mag, out_d;

  jtopl_op_rom u_rom (
    .ls_addr_i  (s1_q.idx),
    .ls_data_o  (ls),
    .exp_addr_i (~s2_q.sum[7:0]),
    .exp_data_o (ex)
  );

  // S1: modulated phase folded into a quarter-wave index
  assign p   = phase_op + mod;
  assign wav = wav_e'(wavsel);

  always_comb begin
    s1_d.idx  = p[8] ? ~p[7:0] : p[7:0];
    s1_d.sign = p[9] & (wav != WAV_ABS) & (wav != WAV_QUART);
    s1_d.mute = ((wav == WAV_HALF) & p[9]) | ((wav == WAV_QUART) & p[8]);
    s1_d.eg   = eg_atten;
  end

  // S2: total attenuation in log domain, clipped at silence
  assign sum_full = {2'b00, ls} + {1'b0, s1_q.eg, 3'b000};

  always_comb begin
    s2_d.sum  = sum_full[13] ? SUM_MAX : sum_full[12:0];
    s2_d.sign = s1_q.sign;
    s2_d.mute = s1_q.mute;
  end

  // S3: mantissa with hidden one, shifted down by the integer part
  assign m   = {1'b1, ex, 1'b0} >> s2_q.sum[12:8];
  assign mag = OUTW'(m);

  always_comb begin
    out_d = '0;
    if (!s2_q.mute) out_d = s2_q.sign ? -mag : mag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      vld_q        <= '0;
      op_out       <= '0;
      op_out_valid <= 1'b0;
    end else if (cen) begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      vld_q        <= {vld_q[0], op_valid};
      op_out       <= out_d;
      op_out_valid <= vld_q[1];
    end
  end

endmodule

// File: tb/tb_jtopl_op_wave.sv
// Directed + streamed checks of jtopl_op_wave against constants and a reference model.
module tb_jtopl_op_wave;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cen = 1'b0;
  logic [9:0]        phase_op = '0, mod = '0, eg_atten = '0;
  logic [1:0]        wavsel = '0;
  logic              op_valid = 1'b0;
  logic signed [13:0] op_out;
  logic              op_out_valid;

  jtopl_op_wave #(.OUTW(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cen          (cen),
    .phase_op     (phase_op),
    .mod          (mod),
    .wavsel       (wavsel),
    .eg_atten     (eg_atten),
    .op_valid     (op_valid),
    .op_out       (op_out),
    .op_out_valid (op_out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; int out;} exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_chk = 0, n_pass = 0;
  int   ls_t[256], ex_t[256];

  logic [9:0] s_ph[32], s_md[32], s_eg[32];
  logic [1:0] s_w[32];
  bit         s_v[32];

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [9:0] ph, input logic [9:0] md,
                                 input logic [1:0] w, input logic [9:0] eg, input bit v);
    logic [9:0] p;
    int idx, sum, m;
    bit sgn, mute;
    exp_t r;
    p    = ph + md;
    idx  = p[8] ? 255 - int'(p[7:0]) : int'(p[7:0]);
    sgn  = p[9] && (w < 2);
    mute = (w == 1 && p[9]) || (w == 3 && p[8]);
    sum  = ls_t[idx] + int'(eg) * 8;
    if (sum > 8191) sum = 8191;
    m    = (2 * (1024 + ex_t[255 - sum % 256])) >> (sum / 256);
    r.v   = v;
    r.out = mute ? 0 : (sgn ? -m : m);
    return r;
  endfunction

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      cen = 1'(i % 2);
      phase_op = 10'($urandom); mod = 10'($urandom);
      wavsel = 2'($urandom); eg_atten = 10'($urandom); op_valid = 1'b1;
      @(posedge clk); #1;
      chk("rst_valid", int'(op_out_valid), 0);
      chk("rst_out", int'(op_out), 0);
    end
    rst_n = 1'b1;
    cen   = 1'b0;
    sb.delete();
    sb.push_back('{0, 0});
    sb.push_back('{0, 0});
    last = '{0, 0};
  endtask

  // idle: cen-low cycles (with junk on the inputs) before the slot's edge
  task automatic slot(input logic [9:0] ph, input logic [9:0] md, input logic [1:0] w,
                      input logic [9:0] eg, input bit v, input bit use_want,
                      input int want, input int idle);
    exp_t e;
    for (int i = 0; i < idle; i++) begin
      cen = 1'b0;
      phase_op = 10'($urandom); mod = 10'($urandom); eg_atten = 10'($urandom);
      wavsel = 2'($urandom); op_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", int'(op_out_valid), int'(last.v));
      if (last.v) chk("hold_out", int'(op_out), last.out);
    end
    phase_op = ph; mod = md; wavsel = w; eg_atten = eg; op_valid = v; cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0;
    e = model(ph, md, w, eg, v);
    if (use_want) e.out = want;
    sb.push_back(e);
    if (sb.size() >= 3) begin
      e = sb.pop_front();
      chk("valid", int'(op_out_valid), int'(e.v));
      if (e.v) chk("out", int'(op_out), e.out);
      last = e;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ls_t[i] = int'(-$ln($sin((real'(i) + 0.5) * 3.14159265358979 / 512.0)) / $ln(2.0) * 256.0);
      ex_t[i] = int'(($pow(2.0, real'(i) / 256.0) - 1.0) * 1024.0);
    end
    for (int i = 0; i < 32; i++) begin
      s_ph[i] = 10'($urandom); s_md[i] = 10'($urandom);
      s_w[i]  = 2'($urandom);  s_eg[i] = 10'($urandom_range(0, 96));
      s_v[i]  = ($urandom_range(0, 3) != 0);
    end

    // reset held with cen toggling, then first valid on the third cen edge
    do_reset(6);
    slot(10'h0FF, 10'h000, 2'd0, 10'h000, 1, 1, 4084, 0);
    slot(10'h100, 10'h000, 2'd0, 10'h000, 1, 1, 4084, 0);
    slot(10'h2FF, 10'h000, 2'd0, 10'h000, 1, 1, -4084, 0);
    slot(10'h000, 10'h000, 2'd0, 10'h000, 1, 1, 12, 0);
    slot(10'h1FF, 10'h000, 2'd0, 10'h000, 1, 1, 12, 0);
    slot(10'h2FF, 10'h000, 2'd1, 10'h000, 1, 1, 0, 1);
    slot(10'h0FF, 10'h000, 2'd1, 10'h000, 1, 1, 4084, 0);
    slot(10'h2FF, 10'h000, 2'd2, 10'h000, 1, 1, 4084, 2);
    slot(10'h1FF, 10'h000, 2'd3, 10'h000, 1, 1, 0, 0);
    slot(10'h0FF, 10'h000, 2'd3, 10'h000, 1, 1, 4084, 0);
    slot(10'h3F0, 10'h020, 2'd0, 10'h000, 1, 0, 0, 0);
    slot(10'h010, 10'h000, 2'd0, 10'h000, 1, 0, 0, 0);
    slot(10'h100, 10'h3FF, 2'd0, 10'h000, 1, 1, 4084, 0);
    slot(10'h0FF, 10'h000, 2'd0, 10'h3FF, 1, 1, 0, 0);
    slot(10'h0FF, 10'h000, 2'd0, 10'h020, 1, 1, 2042, 0);
    slot(10'h2FF, 10'h000, 2'd0, 10'h020, 1, 1, -2042, 0);
    slot(10'h0FF, 10'h000, 2'd0, 10'h180, 1, 1, 0, 0);
    slot(10'h0FF, 10'h000, 2'd0, 10'h000, 0, 0, 0, 0);

    // same slot stream at full rate and at cen duty 1/3
    for (int i = 0; i < 32; i++) slot(s_ph[i], s_md[i], s_w[i], s_eg[i], s_v[i], 0, 0, 0);
    for (int i = 0; i < 32; i++) slot(s_ph[i], s_md[i], s_w[i], s_eg[i], s_v[i], 0, 0, 2);

    // reset mid-stream with cen low: in-flight slots are discarded
    do_reset(1);
    for (int i = 0; i < 8; i++) slot(s_ph[i], s_md[i], s_w[i], s_eg[i], 1, 0, 0, i % 2);
    slot(10'h000, 10'h000, 2'd0, 10'h000, 0, 0, 0, 0);
    slot(10'h000, 10'h000, 2'd0, 10'h000, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
